ext_unit_pipe: RTL and testbench

Parametrised, pipelined extension unit for the single-cycle/pipelined datapath. It replaces the fixed 16→32 sign extender with a mode-selectable immediate/load-data extender covering sign, zero, upper-immediate, byte, halfword and pass-through. It also provides lane selection by byte offset, misalignment detection and a 2-entry valid/ready output buffer. It sits between decode/memory-read and the register writeback/ALU operand mux.

---
 rtl/ext_unit_pipe.sv | 178 +++++++++++++++++
 tb/tb_ext_unit_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ext_unit_pipe.sv
// rtl/ext_unit_pipe.sv - mode-selectable immediate/load-data extender with a 2-entry output buffer
module ext_unit_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] entry0_q, entry0_d;
    logic [W-1:0] entry1_q, entry1_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q,  count_d;
    logic         wr_en, rd_en;

    assign wr_en = push && (count_q != 2'd2);
    assign rd_en = pop  && (count_q != 2'd0);

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            if (wr_ptr_q) entry1_d = wr_data;
            else          entry0_d = wr_data;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (rd_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Empty buffer presents zeros so stale entries never leak onto the output.
    assign rd_data = (count_q == 2'd0) ? '0 : (rd_ptr_q ? entry1_q : entry0_q);
    assign count   = count_q;

endmodule

module ext_unit_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_mode,
    input  logic [OFF_W-1:0]  in_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    typedef enum logic [2:0] {
        MODE_SEXT = 3'd0,
        MODE_ZEXT = 3'd1,
        MODE_LUI  = 3'd2,
        MODE_LB   = 3'd3,
        MODE_LBU  = 3'd4,
        MODE_LH   = 3'd5,
        MODE_LHU  = 3'd6,
        MODE_PASS = 3'd7
    } mode_e;

    localparam int SH_W = OFF_W + 3;

    mode_e             mode;
    logic [IMM_W-1:0]  imm;
    logic [SH_W-1:0]   b_idx;
    logic [SH_W-1:0]   h_idx;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic              push, pop;
    logic [1:0]        count;
    logic [7:0]        err_cnt_q, err_cnt_d;

    assign mode   = mode_e'(in_mode);
    assign imm    = in_data[IMM_W-1:0];
    assign b_idx  = {in_off, 3'b000};
    // Halfword lane ignores in_off[0]; an odd offset is flagged instead of read across lanes.
    assign h_idx  = {in_off[OFF_W-1:1], 4'b0000};
    assign lane_b = in_data[b_idx +: 8];
    assign lane_h = in_data[h_idx +: 16];

    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        case (mode)
            MODE_SEXT: res_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            MODE_ZEXT: res_data = {{(DATA_W-IMM_W){1'b0}}, imm};
            MODE_LUI:  res_data = {imm, {(DATA_W-IMM_W){1'b0}}};
            MODE_LB:   res_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
            MODE_LBU:  res_data = {{(DATA_W-8){1'b0}}, lane_b};
            MODE_LH:   res_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
            MODE_LHU:  res_data = {{(DATA_W-16){1'b0}}, lane_h};
            MODE_PASS: res_data = in_data;
            default:   res_data = '0;
        endcase
        if ((mode == MODE_LH || mode == MODE_LHU) && in_off[0]) begin
            res_err = 1'b1;
        end
        if (mode == MODE_PASS && in_off != '0) begin
            res_err = 1'b1;
        end
        if (res_err) begin
            res_data = '0;
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    ext_unit_fifo2 #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data ({res_err, res_data}),
        .rd_data ({out_err, out_data}),
        .count   (count)
    );

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && res_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb/tb_ext_unit_pipe.sv - directed-vector bench for ext_unit_pipe at DATA_W=32 and DATA_W=64
module tb_ext_unit_pipe;

    localparam logic [2:0] M_SEXT = 3'd0, M_ZEXT = 3'd1, M_LUI = 3'd2, M_LB = 3'd3;
    localparam logic [2:0] M_LBU  = 3'd4, M_LH   = 3'd5, M_LHU = 3'd6, M_PASS = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_err;
    logic [31:0] a_in_data = '0, a_out_data;
    logic [2:0]  a_in_mode = '0;
    logic [1:0]  a_in_off = '0;
    logic [7:0]  a_err_cnt;

    logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1, w_out_err;
    logic [63:0] w_in_data = '0, w_out_data;
    logic [2:0]  w_in_mode = '0;
    logic [2:0]  w_in_off = '0;
    logic [7:0]  w_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ext_unit_pipe #(.DATA_W(32), .IMM_W(16)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_mode(a_in_mode), .in_off(a_in_off),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err(a_out_err), .err_cnt(a_err_cnt)
    );

    ext_unit_pipe #(.DATA_W(64), .IMM_W(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .in_mode(w_in_mode), .in_off(w_in_off),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_err(w_out_err), .err_cnt(w_err_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive32(input logic [2:0] mode, input logic [1:0] off, input logic [31:0] data);
        a_in_valid = 1'b1;
        a_in_mode  = mode;
        a_in_off   = off;
        a_in_data  = data;
    endtask

    task automatic do_op(input bit wide, input logic [2:0] mode, input logic [2:0] off,
                         input logic [63:0] data, input logic [63:0] exp_d,
                         input logic exp_e, input string tag);
        @(negedge clk);
        if (wide) begin
            w_in_valid = 1'b1; w_in_mode = mode; w_in_off = off; w_in_data = data;
        end else begin
            drive32(mode, off[1:0], data[31:0]);
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        w_in_valid = 1'b0;
        if (wide) begin
            check_eq({tag, ".valid"}, 64'(w_out_valid), 64'd1);
            check_eq({tag, ".data"},  w_out_data, exp_d);
            check_eq({tag, ".err"},   64'(w_out_err), 64'(exp_e));
        end else begin
            check_eq({tag, ".valid"}, 64'(a_out_valid), 64'd1);
            check_eq({tag, ".data"},  64'(a_out_data), exp_d);
            check_eq({tag, ".err"},   64'(a_out_err), 64'(exp_e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst.out_valid", 64'(a_out_valid), 64'd0);
        check_eq("rst.out_data",  64'(a_out_data),  64'd0);
        check_eq("rst.err_cnt",   64'(a_err_cnt),   64'd0);
        check_eq("rst.in_ready",  64'(a_in_ready),  64'd1);
        check_eq("rst.w_valid",   64'(w_out_valid), 64'd0);

        do_op(0, M_SEXT, 0, 64'h0000_1234, 64'h0000_1234, 0, "sext_pos");
        do_op(0, M_SEXT, 0, 64'h0000_8765, 64'hFFFF_8765, 0, "sext_neg");
        do_op(0, M_ZEXT, 3, 64'h0000_8765, 64'h0000_8765, 0, "zext");
        do_op(0, M_LUI,  1, 64'h0000_8765, 64'h8765_0000, 0, "lui");
        do_op(0, M_LB,   2, 64'h12F4_5678, 64'hFFFF_FFF4, 0, "lb2");
        do_op(0, M_LBU,  2, 64'h12F4_5678, 64'h0000_00F4, 0, "lbu2");
        do_op(0, M_LB,   3, 64'h12F4_5678, 64'h0000_0012, 0, "lb3");
        do_op(0, M_LH,   2, 64'h12F4_5678, 64'h0000_12F4, 0, "lh2");
        do_op(0, M_LHU,  0, 64'h12F4_5678, 64'h0000_5678, 0, "lhu0");
        do_op(0, M_LH,   1, 64'h12F4_5678, 64'h0000_0000, 1, "lh1_mis");
        do_op(0, M_PASS, 3, 64'h12F4_5678, 64'h0000_0000, 1, "pass3_mis");
        check_eq("err_cnt2", 64'(a_err_cnt), 64'd2);
        do_op(0, M_PASS, 0, 64'h12F4_5678, 64'h12F4_5678, 0, "pass0");
        check_eq("err_cnt2_hold", 64'(a_err_cnt), 64'd2);

        // Backpressure: three requests, only two fit
        @(posedge clk);
        #1;
        check_eq("bp.drained", 64'(a_out_valid), 64'd0);
        @(negedge clk);
        a_out_ready = 1'b0;
        drive32(M_SEXT, 2'd0, 32'h0000_0001);
        @(posedge clk);
        #1;
        check_eq("bp.ready_after1", 64'(a_in_ready), 64'd1);
        check_eq("bp.head1", 64'(a_out_data), 64'h1);
        @(negedge clk);
        drive32(M_ZEXT, 2'd0, 32'h0000_0002);
        @(posedge clk);
        #1;
        check_eq("bp.full", 64'(a_in_ready), 64'd0);
        @(negedge clk);
        drive32(M_LUI, 2'd0, 32'h0000_0003);
        @(posedge clk);
        #1;
        check_eq("bp.still_full", 64'(a_in_ready), 64'd0);
        check_eq("bp.head_held", 64'(a_out_data), 64'h1);
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp.pop1_data", 64'(a_out_data), 64'h2);
        check_eq("bp.pop1_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        check_eq("bp.third_data", 64'(a_out_data), 64'h0003_0000);
        check_eq("bp.third_valid", 64'(a_out_valid), 64'd1);
        @(posedge clk);
        #1;
        check_eq("bp.empty", 64'(a_out_valid), 64'd0);

        // Reset with two entries buffered
        @(negedge clk);
        a_out_ready = 1'b0;
        drive32(M_PASS, 2'd1, 32'hDEAD_BEEF);
        @(negedge clk);
        drive32(M_SEXT, 2'd0, 32'h0000_7FFF);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        check_eq("rm.full", 64'(a_in_ready), 64'd0);
        check_eq("rm.err_cnt", 64'(a_err_cnt), 64'd3);
        check_eq("rm.head_err", 64'(a_out_err), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rm.valid_async", 64'(a_out_valid), 64'd0);
        check_eq("rm.data_async", 64'(a_out_data), 64'd0);
        check_eq("rm.err_cnt_clr", 64'(a_err_cnt), 64'd0);
        check_eq("rm.ready_async", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rm.no_stale", 64'(a_out_valid), 64'd0);
        do_op(0, M_SEXT, 0, 64'h0000_FFFF, 64'hFFFF_FFFF, 0, "post_rst_sext");

        do_op(1, M_LB,   7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0, "w_lb7");
        do_op(1, M_LHU,  6, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_8000, 0, "w_lhu6");
        do_op(1, M_LH,   6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8000, 0, "w_lh6");
        do_op(1, M_SEXT, 5, 64'h0000_0000_0000_8765, 64'hFFFF_FFFF_FFFF_8765, 0, "w_sext");
        do_op(1, M_LUI,  0, 64'h0000_0000_0000_8765, 64'h8765_0000_0000_0000, 0, "w_lui");
        do_op(1, M_PASS, 4, 64'h1234_5678_9ABC_DEF0, 64'h0, 1, "w_pass4_mis");
        check_eq("w_err_cnt", 64'(w_err_cnt), 64'd1);
        do_op(1, M_PASS, 0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 0, "w_pass0");

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
